// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter for the 32x32 register file.
// Two producers (A: single-cycle ALU, B: multi-cycle unit) share one write
// port under round-robin arbitration. A scoreboard tracks registers still
// waiting on a B result, so the issue stage can stall on RAW hazards.
module wb_port_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_valid,
    input  logic [4:0]  A_addr,
    input  logic [31:0] A_data,
    output logic        A_ready,
    input  logic        B_valid,
    input  logic [4:0]  B_addr,
    input  logic [31:0] B_data,
    output logic        B_ready,
    input  logic        Reserve_valid,
    input  logic [4:0]  Reserve_addr,
    output logic        RegWrite,
    output logic [4:0]  Write_address,
    output logic [31:0] Write_data,
    output logic [31:0] Pending,
    output logic        Err
);

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    logic            prio_q, prio_d;
    logic            reg_write_q, reg_write_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    src_e            src_q, src_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic            err_q, err_d;
    logic            grant_a, grant_b;

    // Ready depends only on the competitor's valid and the priority pointer
    always_comb begin
        A_ready = !B_valid || !prio_q;
        B_ready = !A_valid || prio_q;
        grant_a = A_valid && A_ready;
        grant_b = B_valid && B_ready;
    end

    // Next state: output stage, priority pointer, error flag and scoreboard
    always_comb begin
        prio_d      = prio_q;
        reg_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        src_d       = src_q;
        err_d       = err_q;
        pending_d   = pending_q;

        if (grant_a) begin
            prio_d      = 1'b1;
            reg_write_d = (A_addr != '0);
            waddr_d     = A_addr;
            wdata_d     = A_data;
            src_d       = SRC_A;
        end else if (grant_b) begin
            prio_d      = 1'b0;
            reg_write_d = (B_addr != '0);
            waddr_d     = B_addr;
            wdata_d     = B_data;
            src_d       = SRC_B;
            // B result arriving for a register nobody reserved
            if ((B_addr != '0) && !pending_q[B_addr]) begin
                err_d = 1'b1;
            end
        end

        // Clear on commit first so a same-edge reservation wins
        if (reg_write_q && (src_q == SRC_B)) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (Reserve_valid && (Reserve_addr != '0)) begin
            pending_d[Reserve_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset drops any write sitting in the output stage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prio_q      <= 1'b0;
            reg_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            src_q       <= SRC_A;
            pending_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            reg_write_q <= reg_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    // Registered outputs to the register file and issue stage
    always_comb begin
        RegWrite      = reg_write_q;
        Write_address = waddr_q;
        Write_data    = wdata_q;
        Pending       = pending_q;
        Err           = err_q;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// reset and scoreboard sequences, then randomized traffic against a model.
module tb_wb_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        A_valid, B_valid, Reserve_valid;
    logic [4:0]  A_addr, B_addr, Reserve_addr;
    logic [31:0] A_data, B_data;
    logic        A_ready, B_ready;
    logic        RegWrite;
    logic [4:0]  Write_address;
    logic [31:0] Write_data;
    logic [31:0] Pending;
    logic        Err;

    wb_port_arbiter dut (
        .CLK(CLK), .RST(RST),
        .A_valid(A_valid), .A_addr(A_addr), .A_data(A_data), .A_ready(A_ready),
        .B_valid(B_valid), .B_addr(B_addr), .B_data(B_data), .B_ready(B_ready),
        .Reserve_valid(Reserve_valid), .Reserve_addr(Reserve_addr),
        .RegWrite(RegWrite), .Write_address(Write_address), .Write_data(Write_data),
        .Pending(Pending), .Err(Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        av;  logic [4:0] aa; logic [31:0] ad;
        logic        bv;  logic [4:0] ba; logic [31:0] bd;
        logic        rv;  logic [4:0] ra;
        logic        e_ar, e_br, e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_pend;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          from_b;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // Reference model: who wins contention, the write waiting to commit,
    // the set of registers awaiting B, and the sticky error.
    bit          m_fav_b;
    wr_t         m_stage[$];
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    bit          m_pend[32];
    bit          m_err;
    logic        last_a_ready, last_b_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fav_b = 1'b0;
        m_stage.delete();
        m_last_addr = '0;
        m_last_data = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        for (int i = 1; i < 32; i++) p[i] = m_pend[i];
        return p;
    endfunction

    function automatic logic model_rw();
        return (m_stage.size() > 0) && (m_stage[0].addr != 5'd0);
    endfunction

    task automatic model_edge(input vec_t v, input bit ga, input bit gb);
        wr_t w;
        if (gb && v.ba != 5'd0 && !m_pend[v.ba]) m_err = 1'b1;
        if (m_stage.size() > 0) begin
            w = m_stage.pop_front();
            if (w.from_b && w.addr != 5'd0) m_pend[w.addr] = 1'b0;
        end
        if (v.rv && v.ra != 5'd0) m_pend[v.ra] = 1'b1;
        if (ga) begin
            w = '{addr: v.aa, data: v.ad, from_b: 1'b0};
            m_stage.push_back(w);
            m_last_addr = v.aa;
            m_last_data = v.ad;
            m_fav_b = 1'b1;
        end else if (gb) begin
            w = '{addr: v.ba, data: v.bd, from_b: 1'b1};
            m_stage.push_back(w);
            m_last_addr = v.ba;
            m_last_data = v.bd;
            m_fav_b = 1'b0;
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic rv, input logic [4:0] ra,
                                input logic e_ar, input logic e_br, input logic e_rw,
                                input logic [4:0] e_wa, input logic [31:0] e_wd,
                                input logic [31:0] e_pend, input logic e_err);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.rv = rv; v.ra = ra; v.e_ar = e_ar; v.e_br = e_br; v.e_rw = e_rw;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend; v.e_err = e_err;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // One cycle: drive at negedge, check ready, then check registered outputs after the edge
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit ea, eb, ga, gb;
        @(negedge CLK);
        A_valid = v.av; A_addr = v.aa; A_data = v.ad;
        B_valid = v.bv; B_addr = v.ba; B_data = v.bd;
        Reserve_valid = v.rv; Reserve_addr = v.ra;
        #1;
        ea = !(v.bv && m_fav_b);
        eb = !(v.av && !m_fav_b);
        check({tag, " A_ready"}, A_ready, ea);
        check({tag, " B_ready"}, B_ready, eb);
        if (use_tbl) begin
            check({tag, " tbl A_ready"}, A_ready, v.e_ar);
            check({tag, " tbl B_ready"}, B_ready, v.e_br);
        end
        last_a_ready = A_ready;
        last_b_ready = B_ready;
        ga = v.av && ea;
        gb = v.bv && eb;
        @(posedge CLK);
        model_edge(v, ga, gb);
        #1;
        check({tag, " RegWrite"}, RegWrite, model_rw());
        check({tag, " Write_address"}, Write_address, m_last_addr);
        check({tag, " Write_data"}, Write_data, m_last_data);
        check({tag, " Pending"}, Pending, model_pend());
        check({tag, " Err"}, Err, m_err);
        if (use_tbl) begin
            check({tag, " tbl RegWrite"}, RegWrite, v.e_rw);
            check({tag, " tbl Write_address"}, Write_address, v.e_wa);
            check({tag, " tbl Write_data"}, Write_data, v.e_wd);
            check({tag, " tbl Pending"}, Pending, v.e_pend);
            check({tag, " tbl Err"}, Err, v.e_err);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    vec_t tbl[10];

    initial begin
        vec_t r;
        int   a_wait, b_wait;
        bit   a_hold, b_hold;

        RST = 1'b0;
        A_valid = 0; A_addr = 0; A_data = 0;
        B_valid = 0; B_addr = 0; B_data = 0;
        Reserve_valid = 0; Reserve_addr = 0;
        model_reset();
        #7;
        check("reset RegWrite", RegWrite, 0);
        check("reset Pending", Pending, 0);
        check("reset Err", Err, 0);
        RST = 1'b1;

        // Contention, same-edge set/clear on r4, zero address, error, priority after zero write
        //           av aa  ad           bv ba  bd     rv ra ar br rw wa  wd           pend    err
        tbl[0] = mk(0, 0,  0,           0, 0,  0,     1, 4, 1, 1, 0, 0,  0,           32'h10, 0);
        tbl[1] = mk(1, 3,  32'h11,      1, 4,  32'h22, 0, 0, 1, 0, 1, 3,  32'h11,      32'h10, 0);
        tbl[2] = mk(1, 3,  32'h11,      1, 4,  32'h22, 0, 0, 0, 1, 1, 4,  32'h22,      32'h10, 0);
        tbl[3] = mk(1, 3,  32'h12,      1, 4,  32'h23, 1, 4, 1, 0, 1, 3,  32'h12,      32'h10, 0);
        tbl[4] = mk(1, 3,  32'h12,      1, 4,  32'h23, 0, 0, 0, 1, 1, 4,  32'h23,      32'h10, 0);
        tbl[5] = mk(0, 0,  0,           0, 0,  0,     0, 0, 1, 1, 0, 4,  32'h23,      32'h0,  0);
        tbl[6] = mk(1, 0,  32'hFFFFFFFF, 0, 0, 0,     0, 0, 1, 0, 0, 0,  32'hFFFFFFFF, 32'h0, 0);
        tbl[7] = mk(1, 5,  32'h55,      1, 12, 32'h0C, 0, 0, 0, 1, 1, 12, 32'h0C,      32'h0,  1);
        tbl[8] = mk(1, 5,  32'h55,      0, 0,  0,     0, 0, 1, 0, 1, 5,  32'h55,      32'h0,  1);
        tbl[9] = mk(0, 0,  0,           0, 0,  0,     0, 0, 1, 1, 0, 5,  32'h55,      32'h0,  1);
        for (int i = 0; i < 10; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a cycle with a write in the output stage
        r = idle(); r.av = 1; r.aa = 9; r.ad = 32'h99; r.rv = 1; r.ra = 6;
        step(r, 1'b0, "prerst");
        check("prerst RegWrite high", RegWrite, 1);
        #2;
        RST = 1'b0;
        #1;
        check("midrst RegWrite", RegWrite, 0);
        check("midrst Write_address", Write_address, 0);
        check("midrst Write_data", Write_data, 0);
        check("midrst Pending", Pending, 0);
        check("midrst Err", Err, 0);
        model_reset();
        @(negedge CLK);
        A_valid = 0; B_valid = 0; Reserve_valid = 0;
        RST = 1'b1;
        step(idle(), 1'b0, "postrst");
        check("postrst RegWrite low", RegWrite, 0);
        check("postrst A_ready", last_a_ready, 1);
        check("postrst B_ready", last_b_ready, 1);

        // Scoreboard lifecycle on r7: reserve, wait, B write-back, clear on commit
        r = idle(); r.rv = 1; r.ra = 7;
        step(r, 1'b0, "sb0");
        check("sb0 Pending7", Pending[7], 1);
        step(idle(), 1'b0, "sb1");
        check("sb1 Pending7", Pending[7], 1);
        step(idle(), 1'b0, "sb2");
        check("sb2 Pending7", Pending[7], 1);
        r = idle(); r.bv = 1; r.ba = 7; r.bd = 32'h77;
        step(r, 1'b0, "sb3");
        check("sb3 B_ready", last_b_ready, 1);
        check("sb3 Pending7 during commit", Pending[7], 1);
        check("sb3 Write_address", Write_address, 7);
        step(idle(), 1'b0, "sb4");
        check("sb4 Pending7 cleared", Pending[7], 0);
        check("sb4 Err", Err, 0);

        // Randomized traffic; requesters hold their request while stalled
        do_reset();
        a_wait = 0; b_wait = 0; a_hold = 0; b_hold = 0;
        r = idle();
        for (int n = 0; n < 400; n++) begin
            if (!a_hold) begin
                r.av = ($urandom_range(0, 2) != 0);
                r.aa = 5'($urandom_range(0, 7));
                r.ad = $urandom;
            end
            if (!b_hold) begin
                r.bv = ($urandom_range(0, 2) != 0);
                r.ba = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                r.bd = $urandom;
            end
            r.rv = 1'($urandom_range(0, 1));
            r.ra = 5'($urandom_range(0, 7));
            step(r, 1'b0, $sformatf("rnd%0d", n));
            a_hold = r.av && !last_a_ready;
            b_hold = r.bv && !last_b_ready;
            a_wait = a_hold ? a_wait + 1 : 0;
            b_wait = b_hold ? b_wait + 1 : 0;
            if (r.av) check("rnd A wait bound", 32'(a_wait <= 1), 1);
            if (r.bv) check("rnd B wait bound", 32'(b_wait <= 1), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter and pending-register scoreboard for the 32×32 register file. Two producers share the register file's single write port: requester A (single-cycle ALU path) and requester B (multi-cycle unit, e.g. load/mul-div). The block grants one producer per cycle round-robin and drives registered `RegWrite`/`Write_address`/`Write_data` into the register file. It also tracks registers with outstanding B results, so the issue stage can stall on RAW hazards.

## Interface
Parameters:
- None. Fixed at 32 registers × 32 bits; register 0 is hardwired zero.

Ports:
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `A_valid` input 1: A has a write-back request.
- `A_addr` input 5: A destination register.
- `A_data` input 32: A write data.
- `A_ready` output 1: A request accepted this cycle if `A_valid`. Combinational.
- `B_valid`, `B_addr`, `B_data`, `B_ready`: same as the A ports, for requester B.
- `Reserve_valid` input 1: issue stage dispatched a B-bound instruction.
- `Reserve_addr` input 5: its destination register.
- `RegWrite` output 1: to register file, registered.
- `Write_address` output 5: to register file, registered.
- `Write_data` output 32: to register file, registered.
- `Pending` output 32: bit i = register i awaits a B result, registered.
- `Err` output 1: sticky; set on B write-back to a non-pending register.

## Operation
- Priority pointer `prio`: 0 favours A, 1 favours B. Reset value is 0.
- `A_ready = !B_valid || prio==0`. `B_ready = !A_valid || prio==1`.
- grant_A = `A_valid && A_ready`; grant_B = `B_valid && B_ready`. At most one grant per cycle.
- On any grant, `prio` moves to favour the non-granted requester: grant_A sets it to 1, grant_B sets it to 0. With no grant, `prio` holds.
- Output stage on each edge:
  - On a grant: `RegWrite <= (addr != 0)`; `Write_address <= addr`; `Write_data <= data` of the winner; `src <= winner`.
  - With no grant: `RegWrite <= 0`; address and data hold.
- Address 0 requests are accepted normally (ready asserted, `prio` updated), but no write is emitted.
- Scoreboard, evaluated at each edge:
  - Set: `Reserve_valid && Reserve_addr != 0` sets `Pending[Reserve_addr]`.
  - Clear: `RegWrite && src==B` clears `Pending[Write_address]`. The clear lands on the same edge the register file commits the data.
  - Set and clear to the same index on the same edge: set wins, because it is a new reservation.
  - `Pending[0]` is always 0.
- Error: `Err` is set when B is granted with a nonzero addr whose `Pending` bit is 0 (evaluated before that edge's set). `Err` clears only on reset.
- A writes never touch `Pending`.

## Timing
- Reset values: `RegWrite=0`, `Write_address=0`, `Write_data=0`, `Pending=0`, `Err=0`, `prio=0`, `src=A`. Reset is asynchronous and takes effect mid-cycle. Any in-flight output-stage write is dropped and not retried.
- Latency: a request accepted at edge N drives `RegWrite` during cycle N+1. The register file commits at edge N+1.
- Peak throughput is one write per cycle. A requester holding `valid` against a competing requester waits at most one cycle.
- Requesters hold addr and data stable while `valid && !ready`. `ready` depends only on the other requester's `valid` and on `prio`, never on the requester's own `valid`.
- `Pending` for a reservation made at edge N is visible in cycle N+1.

## Test plan
- **Reset and idle.** Deassert `RST` mid-cycle with `RegWrite=1`. Required: all outputs go to 0 immediately. After release with no requests, `RegWrite` stays 0 and both `ready` signals are 1.
- **Contention.** A and B valid continuously; A addr=3/data=0x11, B addr=4/data=0x22, each advancing data on grant. Required: grants alternate A, B, A, B starting with A. `Write_address` sequence is 3, 4, 3, 4, each one cycle after its grant.
- **Zero address.** A valid with addr=0, data=0xFFFFFFFF. Required: `A_ready=1`; the next cycle has `RegWrite=0`; `prio` flips to 1.
- **Scoreboard lifecycle.** Reserve addr=7; 3 cycles later B writes addr=7. Required: `Pending[7]=1` from the cycle after the reserve until the edge at which `RegWrite`/`Write_address=7` from B commits, then 0. `Err` stays 0.
- **Simultaneous set and clear.** Output stage holds a B write to addr 9 while `Reserve_valid` addr=9 is asserted the same cycle. Required: `Pending[9]` remains 1 after the edge.
- **Error.** B writes addr 12 with `Pending[12]=0`. Required: `Err=1` the next cycle and held there until reset. The write to 12 still occurs.
